// File: rtl/task_call_pkg.sv
// rtl/task_call_pkg.sv - shared types and result shaping for the task-call initiator
//   task_id_e    : TASK1..TASK4 call identifiers (2 bits)
//   call_state_e : initiator FSM states
//   call_cmd_t   : queued call descriptor {id, arg}
//   call_res_t   : delivered result {id, data, err}
package task_call_pkg;

  typedef enum logic [1:0] {
    TASK1 = 2'd0,
    TASK2 = 2'd1,
    TASK3 = 2'd2,
    TASK4 = 2'd3
  } task_id_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } call_state_e;

  typedef struct packed {
    task_id_e id;
    logic     arg;
  } call_cmd_t;

  typedef struct packed {
    task_id_e   id;
    logic [1:0] data;
    logic       err;
  } call_res_t;

  // task1/task2 have no output; task3 returns one bit; task4 returns both bits.
  function automatic logic [1:0] shape_result(task_id_e id, logic [1:0] rsp);
    case (id)
      TASK3:   return {1'b0, rsp[0]};
      TASK4:   return rsp;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/task_call_fifo.sv
// rtl/task_call_fifo.sv - synchronous command FIFO of call descriptors
//   clk, rst_n : clock, asynchronous active-low reset (flushes contents)
//   push       : write push_data (ignored when full)
//   pop        : drop the head entry (ignored when empty)
//   head       : current head entry
//   full/empty : occupancy flags decoded from the registered count
module task_call_fifo
  import task_call_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  call_cmd_t push_data,
  input  logic      pop,
  output call_cmd_t head,
  output logic      full,
  output logic      empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  call_cmd_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + (AW+1)'(1);
      end else if (!do_push && do_pop) begin
        count <= count - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/task_call_initiator.sv
// rtl/task_call_initiator.sv - queues task calls, issues them to a responder, returns shaped results
//   clk, rst_n                     : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_id/arg : command input into the FIFO
//   req_valid/req_ready/req_id/arg : call request to the responder
//   rsp_valid/rsp_data             : responder completion pulse and output
//   res_valid/res_ready/res_*      : result stream (res_err marks a timeout)
//   busy                           : call in progress or commands queued
//   err_cnt                        : saturating timeout count
module task_call_initiator
  import task_call_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_id,
  input  logic       cmd_arg,
  output logic       req_valid,
  input  logic       req_ready,
  output logic [1:0] req_id,
  output logic       req_arg,
  input  logic       rsp_valid,
  input  logic [1:0] rsp_data,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [1:0] res_id,
  output logic [1:0] res_data,
  output logic       res_err,
  output logic       busy,
  output logic [7:0] err_cnt
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  call_state_e   state_q;
  call_state_e   state_d;
  call_cmd_t     push_cmd;
  call_cmd_t     fifo_head;
  call_cmd_t     cur_q;
  call_res_t     res_q;
  call_res_t     res_next;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  logic          res_load;
  logic          err_inc;
  logic [CW-1:0] tmo_cnt;
  logic [7:0]    err_cnt_q;

  // cmd_ready comes from the registered occupancy only, so a pop while
  // full frees the slot for the following cycle, not the current one.
  assign cmd_ready = !fifo_full;
  assign push_cmd  = '{id: task_id_e'(cmd_id), arg: cmd_arg};

  task_call_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cmd_valid && cmd_ready),
    .push_data (push_cmd),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    res_load = 1'b0;
    res_next = res_q;
    err_inc  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A response in the timeout cycle still wins.
        if (rsp_valid) begin
          res_load = 1'b1;
          res_next = '{id: cur_q.id, data: shape_result(cur_q.id, rsp_data), err: 1'b0};
          state_d  = DONE;
        end else if (tmo_cnt == TMO_LAST) begin
          res_load = 1'b1;
          res_next = '{id: cur_q.id, data: 2'b00, err: 1'b1};
          err_inc  = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cur_q     <= '0;
      res_q     <= '0;
      tmo_cnt   <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (fifo_pop) begin
        cur_q <= fifo_head;
      end
      // Held at zero through REQ so WAIT starts counting from the handshake.
      if (state_q == REQ) begin
        tmo_cnt <= '0;
      end else if (state_q == WAIT) begin
        tmo_cnt <= tmo_cnt + CW'(1);
      end
      if (res_load) begin
        res_q <= res_next;
      end
      if (err_inc && (err_cnt_q != 8'hFF)) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign req_valid = (state_q == REQ);
  assign req_id    = cur_q.id;
  assign req_arg   = cur_q.arg;
  assign res_valid = (state_q == DONE);
  assign res_id    = res_q.id;
  assign res_data  = res_q.data;
  assign res_err   = res_q.err;
  assign busy      = (state_q != IDLE) || !fifo_empty;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_task_call_initiator.sv
// tb/tb_task_call_initiator.sv - randomized scoreboard bench for task_call_initiator
module tb_task_call_initiator;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid, cmd_ready, cmd_arg;
  logic [1:0] cmd_id;
  logic       req_valid, req_ready, req_arg;
  logic [1:0] req_id;
  logic       rsp_valid;
  logic [1:0] rsp_data;
  logic       res_valid, res_ready, res_err;
  logic [1:0] res_id, res_data;
  logic       busy;
  logic [7:0] err_cnt;

  task_call_initiator #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_id    (cmd_id),
    .cmd_arg   (cmd_arg),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_id    (req_id),
    .req_arg   (req_arg),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_data  (res_data),
    .res_err   (res_err),
    .busy      (busy),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int id; int arg;} cmd_s;
  typedef struct {int id; int data; int err; int at;} res_s;

  cmd_s gen_q[$];   // commands still to be offered
  cmd_s cmd_q[$];   // commands accepted, not yet requested
  cmd_s req_q[$];   // expected request fields at each handshake
  res_s res_q[$];   // expected results with their first-visible cycle

  int total = 0;
  int bad = 0;
  int rr_pct = 100, rs_pct = 100, cv_pct = 100;
  int k_force = 1, d_force = -1;
  bit stray_en = 1'b0;
  bit pend = 1'b0;
  bit pend_pulse = 1'b0;
  int pend_end = 0;
  int pend_data = 0;
  int acc_cnt = 0;
  int model_err = 0;

  function automatic int shape(int id, int d);
    if (id == 2) return d % 2;
    if (id == 3) return d;
    return 0;
  endfunction

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pin driver: command source, responder and result sink, all decided at negedge.
  initial begin
    int k, d, r;
    cmd_s c;
    cmd_valid = 1'b0; cmd_id = 2'd0; cmd_arg = 1'b0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = 2'd0; res_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cmd_valid = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; res_ready = 1'b0;
        pend = 1'b0;
        continue;
      end
      cmd_valid = 1'b0;
      if (gen_q.size() != 0 && int'($urandom_range(99)) < cv_pct) begin
        cmd_valid = 1'b1;
        cmd_id = 2'(gen_q[0].id);
        cmd_arg = 1'(gen_q[0].arg);
        if (cmd_ready) begin
          cmd_q.push_back(gen_q.pop_front());
          acc_cnt++;
        end
      end
      rsp_valid = 1'b0;
      if (pend && cyc + 1 == pend_end) begin
        pend = 1'b0;
        if (pend_pulse) begin
          rsp_valid = 1'b1;
          rsp_data = 2'(pend_data);
        end
      end else if (!pend && stray_en && $urandom_range(7) == 0) begin
        rsp_valid = 1'b1;
        rsp_data = 2'($urandom_range(3));
      end
      req_ready = 1'b0;
      if (!pend) begin
        req_ready = (int'($urandom_range(99)) < rr_pct);
        if (req_ready && req_valid) begin
          if (cmd_q.size() == 0) begin
            check("req_without_cmd", 1, 0);
          end else begin
            c = cmd_q.pop_front();
            req_q.push_back(c);
            if (k_force != 0) k = k_force;
            else begin
              case ($urandom_range(7))
                0: k = TIMEOUT;
                1: k = TIMEOUT + 1 + int'($urandom_range(1));
                2: k = 1000;
                default: k = 1 + int'($urandom_range(3));
              endcase
            end
            d = (d_force >= 0) ? d_force : int'($urandom_range(3));
            r = cyc + 1;
            if (k <= TIMEOUT) begin
              pend_end = r + k;
              pend_pulse = 1'b1;
              res_q.push_back('{c.id, shape(c.id, d), 0, r + k});
            end else begin
              pend_pulse = (k <= TIMEOUT + 2);
              pend_end = pend_pulse ? r + k : r + TIMEOUT + 1;
              res_q.push_back('{c.id, 0, 1, r + TIMEOUT});
            end
            pend_data = d;
            pend = 1'b1;
          end
        end
      end
      res_ready = (int'($urandom_range(99)) < rs_pct);
    end
  end

  // Monitor: compares requests and results against the scoreboard queues.
  initial begin
    bit active;
    int cur_bits;
    res_s e;
    cmd_s q;
    active = 1'b0;
    cur_bits = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        active = 1'b0;
        continue;
      end
      if (req_valid && req_ready) begin
        if (req_q.size() == 0) check("req_unexpected", 1, 0);
        else begin
          q = req_q.pop_front();
          check("req_id", int'(req_id), q.id);
          check("req_arg", int'(req_arg), q.arg);
        end
      end
      if (res_valid && req_valid) check("req_during_result", 1, 0);
      if (res_valid) begin
        if (!active) begin
          if (res_q.size() == 0) check("res_unexpected", 1, 0);
          else begin
            e = res_q.pop_front();
            check("res_id", int'(res_id), e.id);
            check("res_data", int'(res_data), e.data);
            check("res_err", int'(res_err), e.err);
            check("res_cycle", cyc, e.at);
            if (e.err != 0 && model_err < 255) model_err++;
            check("err_cnt", int'(err_cnt), model_err);
          end
          cur_bits = int'({res_id, res_data, res_err});
          active = 1'b1;
        end else begin
          check("res_stable", int'({res_id, res_data, res_err}), cur_bits);
        end
        if (res_ready) active = 1'b0;
      end
    end
  end

  task automatic cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(int budget);
    int i;
    i = 0;
    while ((gen_q.size() != 0 || cmd_q.size() != 0 || req_q.size() != 0 ||
            res_q.size() != 0 || pend || busy) && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("drain_within_budget", int'(i < budget), 1);
    cycles(2);
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, "_cmd_ready"}, int'(cmd_ready), 1);
    check({tag, "_req_valid"}, int'(req_valid), 0);
    check({tag, "_req_id"}, int'(req_id), 0);
    check({tag, "_req_arg"}, int'(req_arg), 0);
    check({tag, "_res_valid"}, int'(res_valid), 0);
    check({tag, "_res_id"}, int'(res_id), 0);
    check({tag, "_res_data"}, int'(res_data), 0);
    check({tag, "_res_err"}, int'(res_err), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_err_cnt"}, int'(err_cnt), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    cycles(3);
    #1;
    check_reset_vals("por");
    @(negedge clk);
    rst_n = 1'b1;
    cycles(2);

    // task3 arg=1, immediate responder returning 2'b11
    k_force = 1; d_force = 3;
    gen_q.push_back('{2, 1});
    drain(200);

    // task4 then task1 back-to-back, responder returns 2'b10
    d_force = 2;
    gen_q.push_back('{3, 0});
    gen_q.push_back('{0, 1});
    drain(200);

    // timeout with a late pulse, then a silent responder
    d_force = -1;
    k_force = TIMEOUT + 2;
    gen_q.push_back('{1, 1});
    drain(200);
    check("err_cnt_first_timeout", int'(err_cnt), 1);
    k_force = 1000;
    gen_q.push_back('{2, 0});
    drain(200);
    check("err_cnt_second_timeout", int'(err_cnt), 2);

    // response in the very cycle the timeout would fire
    k_force = TIMEOUT;
    gen_q.push_back('{3, 1});
    drain(200);

    // fill while req_ready is low: one call in REQ plus DEPTH queued
    rr_pct = 0; k_force = 1; acc_cnt = 0;
    for (int i = 0; i < DEPTH + 3; i++)
      gen_q.push_back('{int'($urandom_range(3)), int'($urandom_range(1))});
    cycles(12);
    check("fill_accepted", acc_cnt, DEPTH + 1);
    check("fill_cmd_ready", int'(cmd_ready), 0);
    check("fill_busy", int'(busy), 1);
    rr_pct = 100;
    drain(400);

    // result held back by res_ready=0
    rs_pct = 0; k_force = 2;
    gen_q.push_back('{3, 1});
    gen_q.push_back('{2, 0});
    cycles(14);
    check("hold_res_valid", int'(res_valid), 1);
    check("hold_req_valid", int'(req_valid), 0);
    rs_pct = 100;
    drain(200);

    // randomized traffic with stray responder pulses
    rr_pct = 60; rs_pct = 60; cv_pct = 70; k_force = 0; stray_en = 1'b1;
    for (int i = 0; i < 60; i++)
      gen_q.push_back('{int'($urandom_range(3)), int'($urandom_range(1))});
    drain(6000);
    stray_en = 1'b0;

    // reset while WAITing with two commands queued
    rr_pct = 100; rs_pct = 100; cv_pct = 100; k_force = 1000;
    for (int i = 0; i < 3; i++)
      gen_q.push_back('{int'($urandom_range(3)), int'($urandom_range(1))});
    cycles(8);
    check("pre_reset_busy", int'(busy), 1);
    rst_n = 1'b0;
    cycles(2);
    gen_q.delete(); cmd_q.delete(); req_q.delete(); res_q.delete();
    model_err = 0;
    #1;
    check_reset_vals("mid");
    @(negedge clk);
    rst_n = 1'b1;
    cycles(1);
    #1;
    check("post_reset_busy", int'(busy), 0);
    check("post_reset_cmd_ready", int'(cmd_ready), 1);

    // recovery after reset
    k_force = 1;
    gen_q.push_back('{3, 1});
    gen_q.push_back('{0, 0});
    drain(200);
    check("final_busy", int'(busy), 0);
    check("final_cmd_ready", int'(cmd_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
